q2_alu_seq: RTL and testbench

Bit-serial sequencer that drives the q2 one-bit ALU slice. It latches a WIDTH-bit accumulator operand and X operand, then presents one bit pair per clock, LSB first, to the slice along with the flag bit and the opcode. It shifts each `alu_out` bit back into the accumulator and carries `alu_cout` forward as the flag. After WIDTH cycles it reports the WIDTH-bit result and the final flag with a one-cycle `done` pulse.

---
 rtl/q2_alu_seq.sv | 121 ++++++++++++
 tb/tb_q2_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/q2_alu_seq.sv
// Bit-serial sequencer for the q2 one-bit ALU slice: streams A/X LSB first through
// the slice, shifts the slice output back into A and reports result/flag with done.
module q2_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic             cin,
   input  logic             shift_fill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag,
   output logic             alu_a0,
   output logic             alu_x0,
   output logic             alu_x1,
   output logic             alu_f,
   output logic             alu_o0,
   output logic             alu_o1,
   input  logic             alu_out,
   input  logic             alu_cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, x_q;
   logic             f_q;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             flag_q;
   logic             done_q;
   logic             accept;
   logic             last;

   // Handshake: start is taken only while IDLE (including the done cycle);
   // busy is high for exactly the RUN state and mirrors the state register.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == LAST) begin
               last    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         x_q      <= '0;
         f_q      <= 1'b0;
         op_q     <= 2'b00;
         cnt_q    <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a_q   <= acc_in;
            x_q   <= x_in;
            op_q  <= op;
            cnt_q <= '0;
            // Load and NOR seed the flag as a zero detector; add/shift take cin.
            f_q   <= op[1] ? cin : 1'b1;
         end else if (state_q == RUN) begin
            a_q   <= {alu_out, a_q[WIDTH-1:1]};
            x_q   <= x_q >> 1;
            f_q   <= alu_cout;
            cnt_q <= last ? '0 : cnt_q + CW'(1);
            if (last) begin
               result_q <= {alu_out, a_q[WIDTH-1:1]};
               flag_q   <= alu_cout;
               done_q   <= 1'b1;
            end
         end
      end
   end

   assign alu_a0 = a_q[0];
   assign alu_x0 = x_q[0];
   // On the final bit the shift op needs the fill bit in place of X[1].
   assign alu_x1 = (cnt_q == LAST) ? shift_fill : x_q[1];
   assign alu_f  = f_q;
   assign alu_o0 = op_q[0];
   assign alu_o1 = op_q[1];

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign result = result_q;
   assign flag   = flag_q;

endmodule

// File: tb/tb_q2_alu_seq.sv
// Self-checking bench for q2_alu_seq with a behavioural model of the one-bit ALU slice.
module tb_q2_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] acc_in;
   logic [W-1:0] x_in;
   logic         cin;
   logic         shift_fill;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         flag;
   logic         alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
   logic         alu_out, alu_cout;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W:0]   exp_q[$];
   logic         done_prev = 1'b0;

   q2_alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .acc_in     (acc_in),
      .x_in       (x_in),
      .cin        (cin),
      .shift_fill (shift_fill),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .flag       (flag),
      .alu_a0     (alu_a0),
      .alu_x0     (alu_x0),
      .alu_x1     (alu_x1),
      .alu_f      (alu_f),
      .alu_o0     (alu_o0),
      .alu_o1     (alu_o1),
      .alu_out    (alu_out),
      .alu_cout   (alu_cout)
   );

   always #5 clk = ~clk;

   // One-bit slice: load/zero-detect, NOR/zero-detect, full add, shift-in of X[1].
   always_comb begin
      alu_out  = 1'b0;
      alu_cout = 1'b0;
      case ({alu_o1, alu_o0})
         2'b00: begin
            alu_out  = alu_x0;
            alu_cout = alu_f & ~alu_x0;
         end
         2'b01: begin
            alu_out  = ~(alu_a0 | alu_x0);
            alu_cout = alu_f & (alu_a0 | alu_x0);
         end
         2'b10: begin
            alu_out  = alu_a0 ^ alu_x0 ^ alu_f;
            alu_cout = (alu_a0 & alu_x0) | (alu_a0 & alu_f) | (alu_x0 & alu_f);
         end
         default: begin
            alu_out  = alu_x1;
            alu_cout = alu_f;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every done pulse retires the oldest queued expectation.
   always @(negedge clk) begin
      if (done) begin
         check("done_consecutive", {31'b0, done_prev}, 32'd0);
         check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("sb_result_flag", {15'b0, result, flag}, {15'b0, e});
         end
      end
      done_prev = done;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] x, input logic c, input logic sf,
                         input logic [W-1:0] er, input logic ef, input int pulse_at);
      int cycles;
      int busy_cnt;
      start      = 1'b1;
      op         = o;
      acc_in     = a;
      x_in       = x;
      cin        = c;
      shift_fill = sf;
      exp_q.push_back({er, ef});
      step();
      cycles   = 1;
      busy_cnt = 0;
      while (!done && cycles < 3 * W) begin
         // Operands may change freely once accepted; an optional stray start is injected.
         start  = (cycles == pulse_at);
         op     = 2'($urandom_range(0, 3));
         acc_in = W'($urandom);
         x_in   = W'($urandom);
         cin    = 1'($urandom_range(0, 1));
         if (busy) busy_cnt++;
         step();
         cycles++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cycles, W + 1);
      check({tag, "_busy_cycles"}, busy_cnt, W);
      check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int dcount;
      int last_t;
      logic seen;

      rst        = 1'b1;
      start      = 1'b0;
      op         = 2'b00;
      acc_in     = '0;
      x_in       = '0;
      cin        = 1'b0;
      shift_fill = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", {16'b0, result}, 32'd0);
      check("rst_flag", {31'b0, flag}, 32'd0);
      check("rst_alu", {26'b0, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 32'd0);
      step();

      run_op("add_basic", 2'b10, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, -1);
      run_op("add_carry", 2'b10, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, -1);
      run_op("add_cin",   2'b10, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, -1);
      run_op("nor_zero",  2'b01, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 16'h0000, 1'b1, -1);
      run_op("nor_val",   2'b01, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 16'hF0F0, 1'b0, -1);
      run_op("load_zero", 2'b00, 16'hABCD, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, -1);
      run_op("load_val",  2'b00, 16'h5A5A, 16'h8001, 1'b0, 1'b0, 16'h8001, 1'b0, -1);
      run_op("shr_fill1", 2'b11, 16'h1234, 16'h8001, 1'b1, 1'b1, 16'hC000, 1'b1, -1);
      run_op("shr_fill0", 2'b11, 16'hFFFF, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b0, -1);
      run_op("start_ign", 2'b10, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 4);
      step();
      check("start_ign_idle", {31'b0, busy}, 32'd0);

      // start held high: three back-to-back operations, done every W+1 cycles.
      start  = 1'b1;
      op     = 2'b10;
      acc_in = 16'h1111;
      x_in   = 16'h2222;
      cin    = 1'b0;
      repeat (3) exp_q.push_back({16'h3333, 1'b0});
      dcount = 0;
      last_t = 0;
      for (int t = 0; t < 60; t++) begin
         if (t == 35) start = 1'b0;
         if (done) begin
            dcount++;
            check("held_gap", t - last_t, W + 1);
            last_t = t;
         end
         step();
      end
      check("held_count", dcount, 3);
      check("hold_result", {15'b0, result, flag}, {15'b0, 16'h3333, 1'b0});

      // Reset in the middle of a run: no done, result/flag cleared.
      start  = 1'b1;
      op     = 2'b10;
      acc_in = 16'hAAAA;
      x_in   = 16'h5555;
      cin    = 1'b0;
      step();
      start = 1'b0;
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_result", {16'b0, result}, 32'd0);
      check("midrst_flag", {31'b0, flag}, 32'd0);
      seen = 1'b0;
      repeat (W + 5) begin
         if (done) seen = 1'b1;
         step();
      end
      check("midrst_no_done", {31'b0, seen}, 32'd0);
      run_op("add_after_rst", 2'b10, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, -1);
      step();
      step();

      check("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
